// File: rtl/l1_rd_resp.sv
// L1 read-port response stage: issues BRAM reads for accepted addresses and returns tagged data
// in accept order, with a credit counter reserving FIFO space for every in-flight read.
module l1_rd_resp #(
    parameter int unsigned nstrms       = 64,
    parameter int unsigned nstrms_width = $clog2(nstrms),
    parameter int unsigned ptr_width    = 1,
    parameter int unsigned data_width   = 64,
    parameter int unsigned bram_lat     = 2,
    parameter int unsigned fifo_depth   = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              i_addr_v,
    output logic                              i_addr_r,
    input  logic [ptr_width-1:0]              i_addr_ptr,
    input  logic [nstrms_width-1:0]           i_addr_sid,
    output logic                              o_bram_re,
    output logic [nstrms_width+ptr_width-1:0] o_bram_addr,
    input  logic [data_width-1:0]             i_bram_data,
    output logic                              o_rd_v,
    input  logic                              o_rd_r,
    output logic [data_width-1:0]             o_rd_data,
    output logic [nstrms_width-1:0]           o_rd_sid,
    output logic                              o_idle
);
    localparam int unsigned CntW = $clog2(fifo_depth + 1);
    localparam int unsigned PtrW = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
    localparam logic [CntW-1:0] CreditMax = CntW'(fifo_depth);
    localparam logic [PtrW-1:0] PtrLast   = PtrW'(fifo_depth - 1);

    logic [CntW-1:0]         r_credit;
    logic [CntW-1:0]         r_count;
    logic [PtrW-1:0]         r_wptr;
    logic [PtrW-1:0]         r_rptr;
    logic [bram_lat-1:0]     r_pipe_v;
    logic [nstrms_width-1:0] r_pipe_sid [bram_lat];
    logic [nstrms_width-1:0] r_fifo_sid [fifo_depth];
    logic [data_width-1:0]   r_fifo_data [fifo_depth];

    logic w_accept;
    logic w_pop;
    logic w_wr;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrLast) ? '0 : p + PtrW'(1);
    endfunction

    assign i_addr_r    = (r_credit != '0) & ~reset;
    assign w_accept    = i_addr_v & i_addr_r;
    assign o_bram_re   = w_accept;
    assign o_bram_addr = {i_addr_sid, i_addr_ptr};
    assign o_rd_v      = (r_count != '0) & ~reset;
    assign w_pop       = o_rd_v & o_rd_r;
    assign w_wr        = r_pipe_v[bram_lat-1];
    assign o_rd_data   = r_fifo_data[r_rptr];
    assign o_rd_sid    = r_fifo_sid[r_rptr];
    assign o_idle      = (r_credit == CreditMax) & ~reset;

    // A credit is taken at accept and returned only at pop, so the FIFO can never overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_credit <= CreditMax;
        end else if (w_accept && !w_pop) begin
            r_credit <= r_credit - CntW'(1);
        end else if (w_pop && !w_accept) begin
            r_credit <= r_credit + CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pipe_v <= '0;
        end else begin
            r_pipe_v[0] <= w_accept;
            for (int i = 1; i < bram_lat; i++) begin
                r_pipe_v[i] <= r_pipe_v[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        r_pipe_sid[0] <= i_addr_sid;
        for (int i = 1; i < bram_lat; i++) begin
            r_pipe_sid[i] <= r_pipe_sid[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
        end else begin
            if (w_wr) begin
                r_wptr <= ptr_inc(r_wptr);
            end
            if (w_pop) begin
                r_rptr <= ptr_inc(r_rptr);
            end
            if (w_wr && !w_pop) begin
                r_count <= r_count + CntW'(1);
            end else if (w_pop && !w_wr) begin
                r_count <= r_count - CntW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_fifo_sid[r_wptr]  <= r_pipe_sid[bram_lat-1];
            r_fifo_data[r_wptr] <= i_bram_data;
        end
    end

endmodule

// File: doc/l1_rd_resp.md
Name: l1_rd_resp

Overview:
Per-read-port response stage directly downstream of the L1 read-port address calculator. It accepts the computed L1 address (stream id, line pointer) through a valid/ready handshake and issues the L1 BRAM read. It tracks the fixed BRAM read latency and buffers returned data in a credit-protected FIFO. Read data, tagged with its stream id, is returned in order to the AFU through a valid/ready interface. Credits guarantee that no returning BRAM word is ever dropped under AFU backpressure.

Parameters:
nstrms, 64, number of streams
nstrms_width, $clog2(nstrms), stream id width
ptr_width, 1, L1 line pointer width per stream
data_width, 64, BRAM read data width
bram_lat, 2, BRAM read latency in cycles (>=1)
fifo_depth, 4, response FIFO entries (>=1; >=bram_lat+1 for full throughput)

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
i_addr_v  in  1  address request valid
i_addr_r  out  1  address request ready (credit available)
i_addr_ptr  in  ptr_width  L1 line pointer
i_addr_sid  in  nstrms_width  stream id
o_bram_re  out  1  BRAM read enable
o_bram_addr  out  nstrms_width+ptr_width  BRAM address {sid,ptr}
i_bram_data  in  data_width  BRAM read data, valid bram_lat cycles after o_bram_re
o_rd_v  out  1  response valid to AFU
o_rd_r  in  1  response ready from AFU
o_rd_data  out  data_width  response data
o_rd_sid  out  nstrms_width  stream id of response
o_idle  out  1  no request in flight and FIFO empty

Behaviour:
- Reset (synchronous, active-high): credit counter = fifo_depth; latency pipe valid bits = 0; FIFO empty with read/write pointers = 0. While reset is high, i_addr_r=0, o_bram_re=0, o_rd_v=0, and o_idle=0. In the first cycle after reset: i_addr_r=1, o_idle=1.
- Reset mid-operation: in-flight reads and buffered responses are discarded. Late BRAM data arriving after reset is ignored because the pipe valid bits are cleared.
- Credit counter is $clog2(fifo_depth+1) bits wide and counts free slots not yet reserved by in-flight or buffered responses.
- i_addr_r = (credit != 0) & ~reset. It is combinational from registered state only and never depends on i_addr_v.
- Accept = i_addr_v & i_addr_r.
  - o_bram_re = accept, in the same cycle.
  - o_bram_addr = {i_addr_sid, i_addr_ptr}, passed through unmodified; no pointer arithmetic and no wrap handling here.
- Pop = o_rd_v & o_rd_r.
- Credit update each cycle:
  - accept only: credit-1
  - pop only: credit+1
  - both: unchanged
  - neither: unchanged
  - The counter must never underflow or exceed fifo_depth; the bench asserts this.
- Latency pipe: bram_lat stages of {valid, sid}.
  - Stage 0 is loaded with {accept, i_addr_sid}; the pipe shifts every cycle and never stalls.
  - When the last stage is valid, i_bram_data and that stage's sid are written into the FIFO on that edge.
  - A free slot is guaranteed by the credit reservation.
- FIFO: fifo_depth entries of {sid, data}, with registered output.
  - o_rd_v = ~empty.
  - o_rd_data and o_rd_sid show the head entry.
  - Head entry and o_rd_v are held stable while o_rd_v & ~o_rd_r.
  - Write into a full FIFO cannot occur.
  - Simultaneous write and pop on a full or empty FIFO are handled normally. There is no write-to-read bypass.
- Latency: accept in cycle t → o_rd_v first high in cycle t+bram_lat+1. Responses are delivered strictly in accept order.
- Throughput: one accept per cycle sustained when o_rd_r=1 and fifo_depth >= bram_lat+1.
- o_idle = (credit == fifo_depth) & ~reset.

Test Plan:
- Single read: after reset, i_addr_v=1, sid=5, ptr=1 for one cycle, o_rd_r=1 → o_bram_re=1 with o_bram_addr={5,1} the same cycle; o_rd_v=1 with o_rd_sid=5 and BRAM data exactly 3 cycles later (bram_lat=2); o_idle returns to 1 the cycle after the pop.
- Back-to-back: 16 consecutive accepts with sids 0..15 and o_rd_r held 1 → i_addr_r never drops; 16 responses arrive in sid order 0..15 on consecutive cycles starting at cycle t+3.
- Backpressure: o_rd_r=0 while i_addr_v=1 continuously → exactly 4 accepts, then i_addr_r=0. FIFO holds 4 entries with no data lost. Raising o_rd_r for 1 cycle → exactly one pop and one new accept, and credit ends back at 0.
- Simultaneous accept and pop with credit=0: the pop frees a credit, so i_addr_r=1 only in the following cycle; credit stays within 0..4 throughout.
- Reset mid-flight: 3 accepts, then reset asserted for 1 cycle while BRAM data is still returning → after reset, o_rd_v=0, o_idle=1, credit=4, and no stale response ever appears.
- Parameter sweep: bram_lat=1 with fifo_depth=1 → at most one accept every 3 cycles (accept at t, pop at t+2, credit visible at t+3) with o_rd_r=1; ordering is preserved.
